// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, control FSM state encoding and flag bit positions.
// Also consumed by the pipeline control decoder, so keep encodings stable.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND = 4'b0000,
      OP_OR  = 4'b0001,
      OP_ADD = 4'b0010,
      OP_MUL = 4'b0011,
      OP_NOR = 4'b0100,
      OP_DIV = 4'b0101,
      OP_SUB = 4'b0110,
      OP_SLT = 4'b0111,
      OP_SLL = 4'b1000,
      OP_SRL = 4'b1001
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

   // Flag vector layout is {illegal_op, overflow, div_by_zero}.
   localparam int FLAG_BITS = 3;
   localparam int FLAG_DZ   = 0;
   localparam int FLAG_OVF  = 1;
   localparam int FLAG_ILL  = 2;

   function automatic logic is_iterative(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one step per clock.
// Exposes the post-step values so the caller can register the answer on the final step.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op_div,
   input  logic             step,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             finish,
   output logic [WIDTH-1:0] res_next,
   output logic             ovf_next,
   output logic             dz_next
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ALL_STEPS = CW'(WIDTH);

   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic             div_q, div_d;
   logic             dz_q, dz_d;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_trial;
   logic             active;

   assign active = step && (count_q != ALL_STEPS);
   assign finish = step && (count_q == LAST_STEP);

   // hi holds the product high half / partial remainder; lo holds multiplier / dividend->quotient.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH + 1){1'b0}});
      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_trial = div_shift - {1'b0, opnd_q};

      count_d = count_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      opnd_d  = opnd_q;
      div_d   = div_q;
      dz_d    = dz_q;

      if (start) begin
         count_d = '0;
         hi_d    = '0;
         lo_d    = a_in;
         opnd_d  = b_in;
         div_d   = op_div;
         dz_d    = op_div && (b_in == '0);
      end else if (active) begin
         count_d = count_q + 1'b1;
         if (div_q) begin
            // A clear top bit means the trial subtraction did not borrow: keep it.
            if (!div_trial[WIDTH]) begin
               hi_d = div_trial[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_d = div_shift[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
         end
      end
   end

   assign res_next = dz_q ? {WIDTH{1'b1}} : lo_d;
   assign ovf_next = !div_q && (hi_d != '0);
   assign dz_next  = dz_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         opnd_q  <= '0;
         div_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         opnd_q  <= opnd_d;
         div_q   <= div_d;
         dz_q    <= dz_d;
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshakes: logic, add/sub, compare and shifts in one
// cycle; mul/div through the iterative datapath. Result and flags are registered.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int FLAG_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            alu_con,
   input  logic [WIDTH-1:0]      data_a,
   input  logic [WIDTH-1:0]      data_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      result,
   output logic [FLAG_WIDTH-1:0] flag
);

   localparam int SH_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

   alu_state_e            state_q, state_d;
   logic [WIDTH-1:0]      result_q, result_d;
   logic [FLAG_WIDTH-1:0] flag_q, flag_d;

   logic                  accept;
   logic                  iter_start;
   logic                  iter_finish;
   logic [WIDTH-1:0]      iter_res;
   logic                  iter_ovf;
   logic                  iter_dz;

   logic [WIDTH-1:0]      sum;
   logic [WIDTH-1:0]      diff;
   logic                  shift_oob;
   logic [WIDTH-1:0]      quick_res;
   logic [FLAG_WIDTH-1:0] quick_flag;

   assign accept     = in_valid && in_ready;
   assign iter_start = accept && is_iterative(alu_con);

   // Output decode: a new request fits whenever the held result is retiring this edge.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_IDLE: in_ready = 1'b1;
         ST_DONE: begin
            in_ready  = out_ready;
            out_valid = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               state_d = iter_start ? ST_BUSY : ST_DONE;
            end else if (state_q == ST_DONE && out_ready) begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: if (iter_finish) state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Single-cycle operations, evaluated straight from the request inputs.
   always_comb begin
      sum        = data_a + data_b;
      diff       = data_a - data_b;
      shift_oob  = (data_b >= WIDTH_V);
      quick_res  = '0;
      quick_flag = '0;
      case (alu_con)
         OP_AND: quick_res = data_a & data_b;
         OP_OR:  quick_res = data_a | data_b;
         OP_NOR: quick_res = ~(data_a | data_b);
         OP_ADD: begin
            quick_res = sum;
            quick_flag[FLAG_OVF] = (data_a[WIDTH-1] == data_b[WIDTH-1]) &&
                                   (sum[WIDTH-1] != data_a[WIDTH-1]);
         end
         OP_SUB: begin
            quick_res = diff;
            quick_flag[FLAG_OVF] = (data_a[WIDTH-1] != data_b[WIDTH-1]) &&
                                   (diff[WIDTH-1] != data_a[WIDTH-1]);
         end
         OP_SLT: quick_res = {{(WIDTH - 1){1'b0}}, ($signed(data_a) < $signed(data_b))};
         OP_SLL: quick_res = shift_oob ? '0 : (data_a << data_b[SH_W-1:0]);
         OP_SRL: quick_res = shift_oob ? '0 : (data_a >> data_b[SH_W-1:0]);
         OP_MUL, OP_DIV: ;
         default: quick_flag[FLAG_ILL] = 1'b1;
      endcase
   end

   // Flags are rebuilt from scratch for every completed operation.
   always_comb begin
      result_d = result_q;
      flag_d   = flag_q;
      if (accept && !iter_start) begin
         result_d = quick_res;
         flag_d   = quick_flag;
      end else if (state_q == ST_BUSY && iter_finish) begin
         result_d         = iter_res;
         flag_d           = '0;
         flag_d[FLAG_OVF] = iter_ovf;
         flag_d[FLAG_DZ]  = iter_dz;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result_q <= '0;
         flag_q   <= '0;
      end else begin
         result_q <= result_d;
         flag_q   <= flag_d;
      end
   end

   alu_muldiv_iter #(
      .WIDTH(WIDTH)
   ) u_iter (
      .clk     (clk),
      .reset   (reset),
      .start   (iter_start),
      .op_div  (alu_con == OP_DIV),
      .step    (state_q == ST_BUSY),
      .a_in    (data_a),
      .b_in    (data_b),
      .finish  (iter_finish),
      .res_next(iter_res),
      .ovf_next(iter_ovf),
      .dz_next (iter_dz)
   );

   assign result = result_q;
   assign flag   = flag_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: table of vectors through a scoreboard, plus backpressure and reset-abort sequences.
module tb_alu_multicycle;

   localparam int W  = 32;
   localparam int NV = 23;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   alu_con;
   logic [W-1:0] data_a;
   logic [W-1:0] data_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [2:0]   flag;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit fresh    = 1'b1;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic [2:0]   flg;
      int           lat;
   } vec_t;

   typedef struct {
      logic [W-1:0] res;
      logic [2:0]   flg;
      int           lat;
      int           acc;
      string        name;
   } exp_t;

   exp_t sb[$];
   exp_t held;
   vec_t vecs[NV];

   alu_multicycle #(
      .WIDTH(W),
      .FLAG_WIDTH(3)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .alu_con  (alu_con),
      .data_a   (data_a),
      .data_b   (data_b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .flag     (flag)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] res, input logic [2:0] flg, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.res = res; v.flg = flg; v.lat = lat;
      return v;
   endfunction

   // Compares each newly presented result against the oldest expectation; checks hold while stalled.
   task automatic monitor_loop();
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            fresh = 1'b1;
         end else if (out_valid) begin
            if (fresh) begin
               if (sb.size() == 0) begin
                  chk("unexpected_out_valid", 64'd1, 64'd0);
               end else begin
                  e = sb.pop_front();
                  chk($sformatf("%s_result", e.name), 64'(result), 64'(e.res));
                  chk($sformatf("%s_flag", e.name), 64'(flag), 64'(e.flg));
                  chk($sformatf("%s_latency", e.name), 64'(cyc - e.acc + 1), 64'(e.lat));
                  held = e;
               end
               fresh = 1'b0;
            end else begin
               chk($sformatf("%s_hold_result", held.name), 64'(result), 64'(held.res));
               chk($sformatf("%s_hold_flag", held.name), 64'(flag), 64'(held.flg));
            end
            if (out_ready) fresh = 1'b1;
         end
      end
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic issue(input vec_t v, input string name);
      int   waited = 0;
      exp_t e;
      in_valid = 1'b1;
      alu_con  = v.op;
      data_a   = v.a;
      data_b   = v.b;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         chk($sformatf("%s_accept_timeout", name), 64'd0, 64'd1);
         in_valid = 1'b0;
         return;
      end
      e.res = v.res; e.flg = v.flg; e.lat = v.lat; e.acc = cyc + 1; e.name = name;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk($sformatf("%s_drain", name), 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int seen;

      vecs[0]  = mk(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 3'b010, 1);
      vecs[1]  = mk(4'b0011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 3'b010, 33);
      vecs[2]  = mk(4'b0011, 32'd7,         32'd6,         32'd42,        3'b000, 33);
      vecs[3]  = mk(4'b0101, 32'd100,       32'd7,         32'd14,        3'b000, 33);
      vecs[4]  = mk(4'b0101, 32'd5,         32'd0,         32'hFFFF_FFFF, 3'b001, 33);
      vecs[5]  = mk(4'b1000, 32'h1,         32'd31,        32'h8000_0000, 3'b000, 1);
      vecs[6]  = mk(4'b1000, 32'h1,         32'd32,        32'h0,         3'b000, 1);
      vecs[7]  = mk(4'b1001, 32'h8000_0000, 32'd40,        32'h0,         3'b000, 1);
      vecs[8]  = mk(4'b1111, 32'h1234,      32'h5678,      32'h0,         3'b100, 1);
      vecs[9]  = mk(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 3'b000, 1);
      vecs[10] = mk(4'b0001, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 3'b000, 1);
      vecs[11] = mk(4'b0100, 32'h0,         32'h0,         32'hFFFF_FFFF, 3'b000, 1);
      vecs[12] = mk(4'b0110, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 3'b010, 1);
      vecs[13] = mk(4'b0111, 32'hFFFF_FFFF, 32'h1,         32'h1,         3'b000, 1);
      vecs[14] = mk(4'b0111, 32'h1,         32'hFFFF_FFFF, 32'h0,         3'b000, 1);
      vecs[15] = mk(4'b1001, 32'hF000_0000, 32'd4,         32'h0F00_0000, 3'b000, 1);
      vecs[16] = mk(4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         3'b010, 33);
      vecs[17] = mk(4'b0101, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 3'b000, 33);
      vecs[18] = mk(4'b0010, 32'h8000_0000, 32'h8000_0000, 32'h0,         3'b010, 1);
      vecs[19] = mk(4'b1010, 32'h5,         32'h6,         32'h0,         3'b100, 1);
      vecs[20] = mk(4'b0011, 32'h0,         32'd5,         32'h0,         3'b000, 33);
      vecs[21] = mk(4'b0101, 32'd7,         32'd100,       32'h0,         3'b000, 33);
      vecs[22] = mk(4'b1000, 32'h3,         32'd4,         32'h30,        3'b000, 1);

      reset     = 1'b1;
      in_valid  = 1'b1;
      alu_con   = 4'b0010;
      data_a    = 32'd1;
      data_b    = 32'd2;
      out_ready = 1'b1;
      fork
         monitor_loop();
      join_none

      // A request held during reset must be ignored.
      repeat (3) @(posedge clk);
      #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_result", 64'(result), 64'd0);
      chk("reset_flag", 64'(flag), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("reset_no_accept", 64'(seen), 64'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         issue(vecs[i], $sformatf("vec%0d", i));
      end
      drain("table");

      // Backpressure: sub held for five cycles, then retire and accept an add on one edge.
      out_ready = 1'b0;
      issue(mk(4'b0110, 32'd3, 32'd5, 32'hFFFF_FFFE, 3'b000, 1), "bp_sub");
      repeat (5) begin
         @(negedge clk);
         chk("bp_out_valid_held", 64'(out_valid), 64'd1);
         chk("bp_in_ready_low", 64'(in_ready), 64'd0);
         chk("bp_result_held", 64'(result), 64'hFFFF_FFFE);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      issue(mk(4'b0010, 32'd10, 32'd20, 32'd30, 3'b000, 1), "bp_add");
      drain("bp");

      // Reset in the middle of a divide aborts it silently.
      issue(mk(4'b0101, 32'd1000, 32'd3, 32'd333, 3'b000, 33), "abort_div");
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("busy_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_result", 64'(result), 64'd0);
      chk("abort_flag", 64'(flag), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("abort_no_out_valid", 64'(seen), 64'd0);
      @(posedge clk);
      #1;
      issue(mk(4'b0101, 32'd9, 32'd3, 32'd3, 3'b000, 33), "post_abort_div");
      drain("post_abort");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
